// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-through cache controller with multi-word block refill,
// internal memory-latency counter and optional write-allocate.
//
// state  | meaning
// IDLE   | waiting for a CPU strobe
// READ   | tag lookup for a read
// WRITE  | tag lookup for a write
// RMISS  | issue memory read for word word_idx, load latency counter
// RMEM   | wait for memory read data
// RDATA  | write refill word into cache, forward it to the CPU
// WHIT   | write CPU data into the cache line
// WMEM   | issue memory write, load latency counter
// WWAIT  | wait for memory write to finish
// DONE   | one-cycle completion pulse to the CPU
module cache_ctrl_fsm #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WRITE_ALLOC = 0,
  parameter int IDX_W       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             rw,
  input  logic             match,
  input  logic             valid,
  output logic             rdy,
  output logic             w,
  output logic             mstrobe,
  output logic             mrw,
  output logic             wsel,
  output logic             rsel,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_READ  = 4'd1,
    S_WRITE = 4'd2,
    S_RMISS = 4'd3,
    S_RMEM  = 4'd4,
    S_RDATA = 4'd5,
    S_WHIT  = 4'd6,
    S_WMEM  = 4'd7,
    S_WWAIT = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             alloc;
  logic             hit;

  assign hit      = match & valid;
  assign word_idx = idx;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Latency counter, refill word index and write-allocate flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= '0;
      alloc <= 1'b0;
    end else begin
      case (state)
        S_READ: begin
          if (!hit) begin
            idx   <= '0;
            alloc <= 1'b0;
          end
        end
        S_WRITE: begin
          if (!hit && (WRITE_ALLOC != 0)) begin
            idx   <= '0;
            alloc <= 1'b1;
          end
        end
        S_RMISS, S_WMEM: cnt <= CNT_LOAD;
        S_RMEM, S_WWAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        S_RDATA: begin
          if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
        end
        S_DONE: begin
          idx   <= '0;
          alloc <= 1'b0;
        end
        S_IDLE, S_WHIT: ;
        default: begin
          // Unreachable encodings: scrub the datapath along with the state.
          cnt   <= '0;
          idx   <= '0;
          alloc <= 1'b0;
        end
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = strobe ? (rw ? S_WRITE : S_READ) : S_IDLE;
      S_READ:  state_nxt = hit ? S_DONE : S_RMISS;
      S_WRITE: state_nxt = hit ? S_WHIT : ((WRITE_ALLOC != 0) ? S_RMISS : S_WMEM);
      S_RMISS: state_nxt = S_RMEM;
      S_RMEM:  state_nxt = (cnt == '0) ? S_RDATA : S_RMEM;
      S_RDATA: state_nxt = (idx == IDX_LAST) ? (alloc ? S_WHIT : S_DONE) : S_RMISS;
      S_WHIT:  state_nxt = S_WMEM;
      S_WMEM:  state_nxt = S_WWAIT;
      S_WWAIT: state_nxt = (cnt == '0) ? S_DONE : S_WWAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode; illegal encodings leave everything low.
  always_comb begin
    rdy     = 1'b0;
    w       = 1'b0;
    mstrobe = 1'b0;
    mrw     = 1'b0;
    wsel    = 1'b0;
    rsel    = 1'b0;
    busy    = 1'b0;
    case (state)
      S_READ, S_WRITE, S_RMEM: busy = 1'b1;
      S_RMISS: begin
        busy    = 1'b1;
        mstrobe = 1'b1;
      end
      S_RDATA: begin
        busy = 1'b1;
        w    = 1'b1;
        wsel = 1'b1;
        rsel = 1'b1;
      end
      S_WHIT: begin
        busy = 1'b1;
        w    = 1'b1;
      end
      S_WMEM: begin
        busy    = 1'b1;
        mstrobe = 1'b1;
        mrw     = 1'b1;
      end
      S_WWAIT: begin
        busy = 1'b1;
        mrw  = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        rdy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
